// File: rtl/cache_victim_wbbuf.sv
// cache_victim_wbbuf: single-entry dirty-victim buffer that drains a cache line to the bus as a beat burst.
module cache_victim_wbbuf #(
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int PA_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Capture,
  input  logic               VictimDirty,
  input  logic [PA_BITS-1:0] VictimAdr,
  input  logic [LINELEN-1:0] VictimLine,
  output logic               Busy,
  output logic               Accepted,
  output logic               BusValid,
  input  logic               BusReady,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusData,
  output logic               BusLast,
  output logic               Done,
  input  logic [PA_BITS-1:0] SnoopAdr,
  output logic               SnoopHit
);
  localparam int BEATS    = LINELEN / BEATLEN;
  localparam int LOGBEATS = $clog2(BEATS);
  localparam int OFFLEN   = $clog2(LINELEN / 8);
  localparam int BOFF     = $clog2(BEATLEN / 8);
  typedef enum logic {IDLE, SEND} state_t;
  state_t               state_q, state_d;
  logic [LOGBEATS-1:0]  beat_q, beat_d, nbeat;
  logic [LINELEN-1:0]   line_q, line_d;
  logic [PA_BITS-1:0]   adr_q, adr_d, bus_adr_q, bus_adr_d;
  logic [BEATLEN-1:0]   bus_data_q, bus_data_d;
  logic                 bus_valid_q, bus_valid_d, bus_last_q, bus_last_d, done_q, done_d, xfer;
  // Beat address is the aligned line address with the beat index spliced into the offset bits.
  always_comb begin
    Accepted    = Capture & VictimDirty & (state_q == IDLE);
    xfer        = bus_valid_q & BusReady;
    nbeat       = beat_q + LOGBEATS'(1);
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    adr_d       = adr_q;
    bus_adr_d   = bus_adr_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = bus_valid_q;
    bus_last_d  = bus_last_q;
    done_d      = 1'b0;
    if (Accepted) begin
      state_d     = SEND;
      beat_d      = '0;
      line_d      = VictimLine;
      adr_d       = VictimAdr & ~PA_BITS'(LINELEN / 8 - 1);
      bus_adr_d   = VictimAdr & ~PA_BITS'(LINELEN / 8 - 1);
      bus_data_d  = VictimLine[BEATLEN-1:0];
      bus_valid_d = 1'b1;
      bus_last_d  = 1'b0;
    end else if (xfer && bus_last_q) begin
      state_d     = IDLE;
      beat_d      = '0;
      bus_valid_d = 1'b0;
      bus_last_d  = 1'b0;
      done_d      = 1'b1;
    end else if (xfer) begin
      beat_d      = nbeat;
      bus_adr_d   = adr_q | (PA_BITS'(nbeat) << BOFF);
      bus_data_d  = line_q[nbeat*BEATLEN +: BEATLEN];
      bus_last_d  = nbeat == LOGBEATS'(BEATS - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      adr_q       <= '0;
      bus_adr_q   <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      adr_q       <= adr_d;
      bus_adr_q   <= bus_adr_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      bus_last_q  <= bus_last_d;
      done_q      <= done_d;
    end
  end
  assign Busy     = state_q == SEND;
  assign BusValid = bus_valid_q;
  assign BusAdr   = bus_adr_q;
  assign BusData  = bus_data_q;
  assign BusLast  = bus_last_q;
  assign Done     = done_q;
  assign SnoopHit = Busy & (((SnoopAdr ^ adr_q) >> OFFLEN) == '0);
endmodule

// File: tb/tb_cache_victim_wbbuf.sv
// tb_cache_victim_wbbuf: directed scenario tests for the victim writeback buffer.
module tb_cache_victim_wbbuf;
  logic         clk = 1'b0;
  logic         reset, Capture, VictimDirty, BusReady;
  logic [31:0]  VictimAdr, SnoopAdr, BusAdr;
  logic [511:0] VictimLine, line_a, line_b;
  logic [63:0]  BusData;
  logic         Busy, Accepted, BusValid, BusLast, Done, SnoopHit;
  int           checks = 0;
  int           passed = 0;
  cache_victim_wbbuf dut (
    .clk(clk), .reset(reset), .Capture(Capture), .VictimDirty(VictimDirty),
    .VictimAdr(VictimAdr), .VictimLine(VictimLine), .Busy(Busy), .Accepted(Accepted),
    .BusValid(BusValid), .BusReady(BusReady), .BusAdr(BusAdr), .BusData(BusData),
    .BusLast(BusLast), .Done(Done), .SnoopAdr(SnoopAdr), .SnoopHit(SnoopHit)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] beat_of(input logic [511:0] l, input int i);
    return l[i*64 +: 64];
  endfunction
  task automatic test_reset;
    reset = 1'b1; Capture = 1'b0; VictimDirty = 1'b0; BusReady = 1'b0;
    VictimAdr = '0; VictimLine = '0; SnoopAdr = '0;
    tick; tick;
    checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", Busy); else passed++;
    checks++; if (BusValid !== 1'b0) $display("FAIL reset_valid got %b exp 0", BusValid); else passed++;
    checks++; if (BusLast !== 1'b0) $display("FAIL reset_last got %b exp 0", BusLast); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL reset_done got %b exp 0", Done); else passed++;
    reset = 1'b0;
    tick;
  endtask
  task automatic test_basic;
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b1; Capture = 1'b1; BusReady = 1'b1;
    #1;
    checks++; if (Accepted !== 1'b1) $display("FAIL basic_accept got %b exp 1", Accepted); else passed++;
    checks++; if (BusValid !== 1'b0) $display("FAIL basic_nobypass got %b exp 0", BusValid); else passed++;
    tick;
    Capture = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (BusValid !== 1'b1) $display("FAIL basic_valid%0d got %b exp 1", i, BusValid); else passed++;
      checks++; if (BusAdr !== 32'h8000_1200 + 32'(8*i)) $display("FAIL basic_adr%0d got %h exp %h", i, BusAdr, 32'h8000_1200 + 32'(8*i)); else passed++;
      checks++; if (BusData !== beat_of(line_a, i)) $display("FAIL basic_data%0d got %h exp %h", i, BusData, beat_of(line_a, i)); else passed++;
      checks++; if (BusLast !== (i == 7)) $display("FAIL basic_last%0d got %b exp %b", i, BusLast, i == 7); else passed++;
      checks++; if (Busy !== 1'b1) $display("FAIL basic_busy%0d got %b exp 1", i, Busy); else passed++;
      tick;
    end
    checks++; if (Done !== 1'b1) $display("FAIL basic_done got %b exp 1", Done); else passed++;
    checks++; if (Busy !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", Busy); else passed++;
    checks++; if (BusValid !== 1'b0) $display("FAIL basic_valid_end got %b exp 0", BusValid); else passed++;
    tick;
    checks++; if (Done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", Done); else passed++;
  endtask
  task automatic test_backpressure;
    int exp_b[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    bit rdy[11]   = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b1; Capture = 1'b1; BusReady = 1'b1;
    tick;
    Capture = 1'b0;
    for (int k = 0; k < 11; k++) begin
      BusReady = rdy[k];
      checks++; if (BusValid !== 1'b1) $display("FAIL bp_valid%0d got %b exp 1", k, BusValid); else passed++;
      checks++; if (BusAdr !== 32'h8000_1200 + 32'(8*exp_b[k])) $display("FAIL bp_adr%0d got %h exp %h", k, BusAdr, 32'h8000_1200 + 32'(8*exp_b[k])); else passed++;
      checks++; if (BusData !== beat_of(line_a, exp_b[k])) $display("FAIL bp_data%0d got %h exp %h", k, BusData, beat_of(line_a, exp_b[k])); else passed++;
      tick;
    end
    BusReady = 1'b1;
    checks++; if (Done !== 1'b1) $display("FAIL bp_done got %b exp 1", Done); else passed++;
  endtask
  task automatic test_reject;
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b0; Capture = 1'b1; BusReady = 1'b1;
    #1;
    checks++; if (Accepted !== 1'b0) $display("FAIL clean_accept got %b exp 0", Accepted); else passed++;
    tick;
    checks++; if (Busy !== 1'b0) $display("FAIL clean_busy got %b exp 0", Busy); else passed++;
    checks++; if (BusValid !== 1'b0) $display("FAIL clean_valid got %b exp 0", BusValid); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL clean_done got %b exp 0", Done); else passed++;
    VictimDirty = 1'b1;
    tick;
    VictimAdr = 32'h9000_0000; VictimLine = line_b;
    #1;
    checks++; if (Accepted !== 1'b0) $display("FAIL busy_accept got %b exp 0", Accepted); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (BusAdr !== 32'h8000_1200 + 32'(8*i)) $display("FAIL busy_adr%0d got %h exp %h", i, BusAdr, 32'h8000_1200 + 32'(8*i)); else passed++;
      checks++; if (BusData !== beat_of(line_a, i)) $display("FAIL busy_data%0d got %h exp %h", i, BusData, beat_of(line_a, i)); else passed++;
      if (i == 7) Capture = 1'b0;
      tick;
    end
    checks++; if (Done !== 1'b1) $display("FAIL busy_done got %b exp 1", Done); else passed++;
    tick;
  endtask
  task automatic test_back_to_back;
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b1; Capture = 1'b1; BusReady = 1'b1;
    tick;
    Capture = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        VictimAdr = 32'hA000_0040; VictimLine = line_b; Capture = 1'b1;
        #1;
        checks++; if (Accepted !== 1'b0) $display("FAIL b2b_lastbeat_accept got %b exp 0", Accepted); else passed++;
        checks++; if (BusLast !== 1'b1) $display("FAIL b2b_last got %b exp 1", BusLast); else passed++;
      end
      tick;
    end
    checks++; if (Done !== 1'b1) $display("FAIL b2b_done got %b exp 1", Done); else passed++;
    checks++; if (Accepted !== 1'b1) $display("FAIL b2b_accept got %b exp 1", Accepted); else passed++;
    tick;
    Capture = 1'b0;
    checks++; if (BusValid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", BusValid); else passed++;
    checks++; if (BusAdr !== 32'hA000_0040) $display("FAIL b2b_adr got %h exp a0000040", BusAdr); else passed++;
    checks++; if (BusData !== beat_of(line_b, 0)) $display("FAIL b2b_data got %h exp %h", BusData, beat_of(line_b, 0)); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL b2b_done_pulse got %b exp 0", Done); else passed++;
    repeat (8) tick;
    checks++; if (Done !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", Done); else passed++;
    tick;
  endtask
  task automatic test_snoop;
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b1; Capture = 1'b1; BusReady = 1'b0;
    tick;
    Capture = 1'b0;
    SnoopAdr = 32'h8000_123F;
    #1;
    checks++; if (SnoopHit !== 1'b1) $display("FAIL snoop_hit got %b exp 1", SnoopHit); else passed++;
    SnoopAdr = 32'h8000_1240;
    #1;
    checks++; if (SnoopHit !== 1'b0) $display("FAIL snoop_miss got %b exp 0", SnoopHit); else passed++;
    SnoopAdr = 32'h8000_1200;
    #1;
    checks++; if (SnoopHit !== 1'b1) $display("FAIL snoop_base got %b exp 1", SnoopHit); else passed++;
    checks++; if (BusAdr !== 32'h8000_1200) $display("FAIL snoop_stall_adr got %h exp 80001200", BusAdr); else passed++;
    BusReady = 1'b1;
    repeat (8) tick;
    checks++; if (Done !== 1'b1) $display("FAIL snoop_done got %b exp 1", Done); else passed++;
    SnoopAdr = 32'h8000_123F;
    #1;
    checks++; if (SnoopHit !== 1'b0) $display("FAIL snoop_idle got %b exp 0", SnoopHit); else passed++;
    tick;
  endtask
  task automatic test_reset_mid;
    VictimAdr = 32'h8000_1234; VictimLine = line_a; VictimDirty = 1'b1; Capture = 1'b1; BusReady = 1'b1;
    tick;
    Capture = 1'b0;
    repeat (4) tick;
    checks++; if (BusAdr !== 32'h8000_1220) $display("FAIL rst_beat4_adr got %h exp 80001220", BusAdr); else passed++;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (BusValid !== 1'b0) $display("FAIL rst_valid got %b exp 0", BusValid); else passed++;
    checks++; if (Busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", Busy); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL rst_done got %b exp 0", Done); else passed++;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (BusValid !== 1'b0 || Done !== 1'b0) $display("FAIL rst_quiet%0d got valid %b done %b exp 0 0", k, BusValid, Done); else passed++;
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) line_a[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    line_b = ~line_a;
    test_reset;
    test_basic;
    test_backpressure;
    test_reject;
    test_back_to_back;
    test_snoop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
